tc_accum_reduce: RTL and testbench
==================================

// Module: tc_accum_reduce
// PURPOSE
//  Consumer of the PE-array product bus. Per PE, reduces N lane products with a pipelined
//  adder tree, then accumulates the row sums over successive K-chunks of a tile.
//  On the chunk flagged last, emits one DW_ACC sum per PE through a valid/ready output.
//  Sits directly downstream of the tensor-core multiply array, upstream of writeback.
// PARAMETERS
//  N_PE     4            number of PEs (independent reduction lanes)
//  N        16           products per PE; power of two, >=2
//  N_UNIT   N_PE*N       total product lanes (derived, do not override)
//  DW_DATA  32           product width, two's complement
//  DW_ACC   40           accumulator/output width; must be >= DW_DATA+log2(N)
//  CNT_W    8            width of the per-tile chunk counter
// PORTS
//  clk        in   1                 clock, all state on rising edge
//  reset_n    in   1                 asynchronous, active-low reset
//  in_valid   in   1                 product bus carries a valid K-chunk
//  in_ready   out  1                 block accepts the chunk this cycle
//  in_last    in   1                 chunk is the final one of the tile
//  in_prod    in   N_UNIT*DW_DATA    products; PE p owns lanes [p*N, p*N+N-1]
//  out_valid  out  1                 out_sum/out_cnt hold a finished tile
//  out_ready  in   1                 downstream consumes the tile result
//  out_sum    out  N_PE*DW_ACC       per-PE accumulated sums, PE p at [p*DW_ACC +: DW_ACC]
//  out_cnt    out  CNT_W             number of chunks accumulated into this result
// BEHAVIOUR
//  - Reset (async, reset_n=0): all pipeline valids, accumulators, out_sum, out_cnt, out_valid -> 0;
//    first-chunk flag -> 1. in_ready is combinational and reads 1 once reset is released.
//  - Global enable en = !out_valid | out_ready; in_ready = en. Handshake on in_valid & in_ready.
//    When en=0 the whole pipeline (tree stages, valid/last shift, accumulator) holds.
//  - Products sign-extended to DW_ACC before the tree; tree has L=log2(N) registered stages,
//    each stage halves the operand count. All adds wrap modulo 2^DW_ACC (see CONFIGURATION).
//  - Accumulate stage (tree output valid & en): acc <= (first ? 0 : acc) + tree_sum;
//    cnt <= first ? 1 : sat(cnt+1) (saturates at 2^CNT_W-1); first <= last.
//  - If tree output carries last: out_sum <= acc_next, out_cnt <= cnt_next, out_valid <= 1;
//    acc/cnt restart on the next chunk (first=1).
//  - out_valid clears on out_valid & out_ready unless a new last completes the same cycle
//    (then stays 1 with new data). out_sum/out_cnt stable while out_valid & !out_ready.
//  - Latency: last chunk accepted at cycle t -> out_valid at t+L+1 absent stalls (L=4 -> 5).
//  - Throughput: one chunk per cycle; single-chunk tiles (in_last every beat) fully pipelined.
//  - Bubbles (in_valid=0) propagate as invalid tree slots; they never touch acc or cnt.
//  - Reset mid-tile discards partial accumulation and any pending result without output.
// CONFIGURATION
//  TC_ACC_SAT_EN defined: the accumulate-stage add saturates to signed DW_ACC limits
//    (+2^(DW_ACC-1)-1 / -2^(DW_ACC-1)); tree adds still wrap (sized not to overflow).
//  Not defined: accumulate add wraps modulo 2^DW_ACC. Ports and latency identical both ways.
// STRUCTURE
//  tc_pkg: clog2 function, DW_DATA/DW_ACC defaults, tree-depth constant L, sat helper.
//  Sub-module tc_add_tree (N inputs, DW_ACC, L registered stages, enable, valid/last
//  sideband), instantiated N_PE times; accumulator, counter, output register and
//  handshake in tc_accum_reduce.
// TESTING
//  1) Defaults, one chunk, all products=1, in_last=1 -> 5 cycles later out_sum=16 per PE, out_cnt=1.
//  2) 3 chunks PE0 lanes=2,3,-1 (others 0) last on 3rd -> out_sum PE0=64, others 0, out_cnt=3.
//  3) Hold out_ready=0 with a result pending, keep in_valid=1 -> in_ready=0, out_sum unchanged;
//     release -> next tile emerges after pipeline resumes, no chunk lost or duplicated.
//  4) Back-to-back single-chunk tiles, out_ready=1, values k=1..8 -> 8 results k*16, one/cycle.
//  5) TC_ACC_SAT_EN, DW_ACC=40, repeated chunks of 0x7FFFFFFF -> sum clamps at 2^39-1; without
//     macro same stimulus wraps negative.
//  6) Drop reset_n mid-tile after 2 chunks -> out_valid=0 immediately; next tile sums from 0.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared defaults and helpers for the tensor-core accumulate/reduce slice.
package tc_pkg;

  localparam int N_PE_DEF    = 4;
  localparam int N_DEF       = 16;
  localparam int DW_DATA_DEF = 32;
  localparam int DW_ACC_DEF  = 40;
  localparam int CNT_W_DEF   = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
      else r = r;
    end
    return r;
  endfunction

  localparam int L_DEF = clog2(N_DEF);

  // Signed add clamped to the range of a w-bit two's complement value (w <= 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    else if (s < lo) return lo;
    else return s;
  endfunction

endpackage

// File: rtl/tc_add_tree.sv
// Pipelined N-input adder tree, one registered level per halving, with a
// valid/last sideband that shifts alongside the data.
module tc_add_tree
  import tc_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_ACC_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            in_valid,
  input  logic            in_last,
  input  logic [N*DW-1:0] in_data,
  output logic            out_valid,
  output logic            out_last,
  output logic [DW-1:0]   out_sum
);

  localparam int L = clog2(N);

  // Heap layout: indices 1..N-1 are registered nodes, N..2N-1 are the input lanes.
  logic [DW-1:0] node_r [1:N-1];
  logic [DW-1:0] leaf_s [1:2*N-1];
  logic [L-1:0]  vld_r;
  logic [L-1:0]  last_r;

  for (genvar k = 1; k < 2 * N; k++) begin : g_heap
    if (k < N) begin : g_node
      assign leaf_s[k] = node_r[k];
    end else begin : g_lane
      assign leaf_s[k] = in_data[(k-N)*DW +: DW];
    end
  end

  // Every node adds its two children; equal leaf depth keeps the levels aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k < N; k++) node_r[k] <= '0;
    end else if (en) begin
      for (int k = 1; k < N; k++) node_r[k] <= leaf_s[2*k] + leaf_s[2*k+1];
    end
  end

  // Sideband shift; last is only meaningful on a valid slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_r  <= '0;
      last_r <= '0;
    end else if (en) begin
      vld_r[0]  <= in_valid;
      last_r[0] <= in_valid & in_last;
      for (int s = 1; s < L; s++) begin
        vld_r[s]  <= vld_r[s-1];
        last_r[s] <= last_r[s-1];
      end
    end
  end

  assign out_valid = vld_r[L-1];
  assign out_last  = last_r[L-1];
  assign out_sum   = node_r[1];

endmodule

// File: rtl/tc_accum_reduce.sv
// Per-PE lane reduction plus K-chunk accumulation with a valid/ready tile result.
// Define TC_ACC_SAT_EN to make the accumulate add saturate instead of wrap.
module tc_accum_reduce
  import tc_pkg::*;
#(
  parameter int N_PE    = N_PE_DEF,
  parameter int N       = N_DEF,
  parameter int DW_DATA = DW_DATA_DEF,
  parameter int DW_ACC  = DW_ACC_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [N_PE*N*DW_DATA-1:0] in_prod,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_PE*DW_ACC-1:0]    out_sum,
  output logic [CNT_W-1:0]          out_cnt
);

  logic                    en_s;
  logic [N*DW_ACC-1:0]     tree_in_s   [N_PE];
  logic [DW_ACC-1:0]       tree_sum_s  [N_PE];
  logic [N_PE-1:0]         tree_vld_s;
  logic [N_PE-1:0]         tree_last_s;
  logic [DW_ACC-1:0]       acc_r       [N_PE];
  logic [DW_ACC-1:0]       acc_base_s  [N_PE];
  logic [DW_ACC-1:0]       acc_next_s  [N_PE];
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_next_s;
  logic                    first_r;
  logic                    fire_s;
  logic                    done_s;
  logic                    out_valid_r;
  logic [N_PE*DW_ACC-1:0]  out_sum_r;
  logic [CNT_W-1:0]        out_cnt_r;

  // A held result freezes the entire pipeline, so nothing in flight is lost.
  assign en_s     = !out_valid_r || out_ready;
  assign in_ready = en_s;

  // Sign-extend every product to accumulator width before reduction.
  always_comb begin
    for (int p = 0; p < N_PE; p++) begin
      tree_in_s[p] = '0;
      for (int i = 0; i < N; i++) begin
        tree_in_s[p][i*DW_ACC +: DW_ACC] = DW_ACC'($signed(in_prod[(p*N+i)*DW_DATA +: DW_DATA]));
      end
    end
  end

  for (genvar p = 0; p < N_PE; p++) begin : g_pe
    tc_add_tree #(.N(N), .DW(DW_ACC)) u_tree (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en_s),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_data  (tree_in_s[p]),
      .out_valid(tree_vld_s[p]),
      .out_last (tree_last_s[p]),
      .out_sum  (tree_sum_s[p])
    );
  end

  assign fire_s = (&tree_vld_s) && en_s;
  assign done_s = fire_s && (&tree_last_s);

  // Next accumulator and chunk count; the first chunk of a tile restarts both.
  always_comb begin
    if (first_r) cnt_next_s = CNT_W'(1);
    else if (cnt_r == {CNT_W{1'b1}}) cnt_next_s = cnt_r;
    else cnt_next_s = cnt_r + CNT_W'(1);
    for (int p = 0; p < N_PE; p++) begin
      acc_base_s[p] = first_r ? {DW_ACC{1'b0}} : acc_r[p];
`ifdef TC_ACC_SAT_EN
      acc_next_s[p] = DW_ACC'(sat_add(64'(signed'(acc_base_s[p])),
                                      64'(signed'(tree_sum_s[p])), DW_ACC));
`else
      acc_next_s[p] = acc_base_s[p] + tree_sum_s[p];
`endif
    end
  end

  // Running accumulation state, advanced only by valid tree outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < N_PE; p++) acc_r[p] <= '0;
      cnt_r   <= '0;
      first_r <= 1'b1;
    end else if (fire_s) begin
      for (int p = 0; p < N_PE; p++) acc_r[p] <= acc_next_s[p];
      cnt_r   <= cnt_next_s;
      first_r <= &tree_last_s;
    end
  end

  // Tile result register; a completing tile wins over a same-cycle drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_cnt_r   <= '0;
    end else if (done_s) begin
      out_valid_r <= 1'b1;
      for (int p = 0; p < N_PE; p++) out_sum_r[p*DW_ACC +: DW_ACC] <= acc_next_s[p];
      out_cnt_r   <= cnt_next_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_cnt   = out_cnt_r;

endmodule

// File: tb/tb_tc_accum_reduce.sv
// Randomized and directed bench for tc_accum_reduce against a tile-level reference model.
module tb_tc_accum_reduce;

  localparam int N_PE    = 4;
  localparam int N       = 16;
  localparam int DW_DATA = 32;
  localparam int DW_ACC  = 40;
  localparam int CNT_W   = 8;
  localparam int N_UNIT  = N_PE * N;
  localparam int LAT     = 5;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_last;
  logic [N_UNIT*DW_DATA-1:0]   in_prod;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_PE*DW_ACC-1:0]      out_sum;
  logic [CNT_W-1:0]            out_cnt;

  tc_accum_reduce #(
    .N_PE(N_PE), .N(N), .DW_DATA(DW_DATA), .DW_ACC(DW_ACC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_prod(in_prod), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit lat_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: whole tiles computed with plain integer arithmetic at acceptance time.
  typedef struct {
    logic [N_PE*DW_ACC-1:0] sum;
    int cnt;
    int cyc;
  } res_t;

  longint m_acc [N_PE];
  int     m_cnt;
  bit     m_first;
  res_t   exp_q [$];

  bit                     held = 1'b0;
  logic [N_PE*DW_ACC-1:0] held_sum;
  logic [CNT_W-1:0]       held_cnt;

  function automatic longint acc_add(input longint a, input longint b);
    longint s;
    longint hi;
    longint lo;
    s  = a + b;
    hi = (longint'(1) <<< (DW_ACC - 1)) - 1;
    lo = -hi - 1;
`ifdef TC_ACC_SAT_EN
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`else
    s = (s <<< (64 - DW_ACC)) >>> (64 - DW_ACC);
`endif
    return s;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N_PE; p++) m_acc[p] = 0;
    m_cnt   = 0;
    m_first = 1'b1;
    exp_q.delete();
    held = 1'b0;
  endtask

  task automatic model_accept();
    res_t r;
    longint rs;
    for (int p = 0; p < N_PE; p++) begin
      rs = 0;
      for (int i = 0; i < N; i++) rs += longint'($signed(in_prod[(p*N+i)*DW_DATA +: DW_DATA]));
      m_acc[p] = acc_add(m_first ? 64'sd0 : m_acc[p], rs);
    end
    m_cnt   = m_first ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    m_first = in_last;
    if (in_last) begin
      for (int p = 0; p < N_PE; p++) r.sum[p*DW_ACC +: DW_ACC] = m_acc[p][DW_ACC-1:0];
      r.cnt = m_cnt;
      r.cyc = cyc;
      exp_q.push_back(r);
    end
  endtask

  // One clock: inputs are already set; evaluate what the coming edge sees, then advance.
  task automatic tick(output bit accepted);
    res_t r;
    #1;
    accepted = in_valid && in_ready;
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (held) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum == held_sum, 1);
      chk("hold_cnt", out_cnt, held_cnt);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        r = exp_q.pop_front();
        for (int p = 0; p < N_PE; p++)
          chk($sformatf("sum_pe%0d", p), out_sum[p*DW_ACC +: DW_ACC], r.sum[p*DW_ACC +: DW_ACC]);
        chk("cnt", out_cnt, r.cnt);
        if (lat_chk) chk("latency", cyc - r.cyc, LAT);
      end
    end
    held     = out_valid && !out_ready;
    held_sum = out_sum;
    held_cnt = out_cnt;
    if (accepted) model_accept();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_lanes(input logic [31:0] v0, input logic [31:0] vo);
    for (int p = 0; p < N_PE; p++)
      for (int i = 0; i < N; i++)
        in_prod[(p*N+i)*DW_DATA +: DW_DATA] = (p == 0) ? v0 : vo;
  endtask

  task automatic send_beat(input logic [31:0] v0, input logic [31:0] vo, input bit last);
    bit a;
    int w;
    in_valid = 1'b1;
    in_last  = last;
    set_lanes(v0, vo);
    w = 0;
    do begin
      tick(a);
      w++;
    end while (!a && w < 100);
    if (!a) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int w;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_prod   = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_sum", out_sum == '0, 1);
    reset_n = 1'b1;
    @(negedge clk);
    #1 chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // 1) single chunk of ones, latency checked
    lat_chk = 1'b1;
    send_beat(32'd1, 32'd1, 1'b1);
    idle(8);

    // 2) three chunks on PE0 only
    send_beat(32'd2, 32'd0, 1'b0);
    send_beat(32'd3, 32'd0, 1'b0);
    send_beat(32'hFFFF_FFFF, 32'd0, 1'b1);
    idle(8);

    // 4) back-to-back single-chunk tiles
    for (int k = 1; k <= 8; k++) send_beat(32'(k), 32'(k), 1'b1);
    idle(8);

    // 5) large products: saturate or wrap depending on build
    for (int k = 0; k < 20; k++) send_beat(32'h7FFF_FFFF, 32'h8000_0000, k == 19);
    idle(8);

    // counter saturation over a long tile
    for (int k = 0; k < 260; k++) send_beat(32'd1, 32'hFFFF_FFFE, k == 259);
    idle(8);

    // 3) back-pressure with traffic still arriving
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        repeat (14) @(negedge clk);
        out_ready = 1'b1;
      end
    join_none
    send_beat(32'd5, 32'd5, 1'b1);
    for (int k = 0; k < 3; k++) send_beat(32'd7, 32'd1, k == 2);
    for (int k = 0; k < 4; k++) send_beat(32'd3, 32'hFFFF_FFFD, k == 3);
    idle(12);
    chk("stall_drained", exp_q.size(), 0);

    // 6) reset mid-tile
    out_ready = 1'b1;
    send_beat(32'd9, 32'd9, 1'b0);
    send_beat(32'd9, 32'd9, 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    lat_chk = 1'b1;
    send_beat(32'd2, 32'd1, 1'b1);
    idle(8);
    lat_chk = 1'b0;

    // randomized traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      for (int u = 0; u < N_UNIT; u++) begin
        if ($urandom_range(0, 3) == 0) in_prod[u*DW_DATA +: DW_DATA] = $urandom;
        else in_prod[u*DW_DATA +: DW_DATA] = 32'($urandom_range(0, 20)) - 32'd10;
      end
      tick(a);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 40) begin
      tick(a);
      w++;
    end
    chk("drain_empty", exp_q.size(), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
